// File: rtl/lcd_frame_prefetch_ctrl_if.sv
// Read-port and display-FIFO signal bundle for lcd_frame_prefetch_ctrl.
//   master : the prefetch controller (drives flush and burst requests)
//   slave  : SDRAM read port plus display FIFO (drives ack/done/fill level)
// Signals:
//   fifo_flush    one-cycle display FIFO clear
//   fifo_wrusedw  words currently held in the display FIFO
//   rd_req        burst read request, held until rd_ack
//   rd_addr       burst start word address
//   rd_len        burst length in words (1..256)
//   rd_ack        SDRAM controller accepted the request
//   rd_done       last word of the burst has been written to the FIFO
interface lcd_frame_prefetch_ctrl_if #(
  parameter int ADDR_W  = 24,
  parameter int USEDW_W = 10
);
  logic                fifo_flush;
  logic [USEDW_W-1:0]  fifo_wrusedw;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [8:0]          rd_len;
  logic                rd_ack;
  logic                rd_done;

  modport master (
    output fifo_flush, rd_req, rd_addr, rd_len,
    input  fifo_wrusedw, rd_ack, rd_done
  );

  modport slave (
    input  fifo_flush, rd_req, rd_addr, rd_len,
    output fifo_wrusedw, rd_ack, rd_done
  );
endinterface

// File: rtl/lcd_frame_prefetch_ctrl.sv
// Frame prefetch sequencer: on each LCD frame start (falling edge of the
// active-low vsync) it flushes the display FIFO and walks the frame buffer
// linearly in SDRAM read bursts, issuing a burst only when the FIFO has room
// for it.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   enable          permits a new frame to start (sampled at frame start)
//   lcd_framesync   LCD vsync, active-low
//   bus             read-port / display-FIFO bundle (master side)
//   frame_done      one-cycle pulse when the whole frame has been fetched
//   busy            high whenever the sequencer is not idle
//   overrun_cnt     saturating count of frame starts that arrived while busy
module lcd_frame_prefetch_ctrl #(
  parameter int H_DISP     = 480,
  parameter int V_DISP     = 272,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 24,
  parameter int BASE_ADDR  = 0,
  parameter int CNT_W      = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       lcd_framesync,
  lcd_frame_prefetch_ctrl_if.master  bus,
  output logic                       frame_done,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt
);

  localparam int USEDW_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0]   FRAME_WORDS = CNT_W'(H_DISP * V_DISP);
  localparam logic [CNT_W-1:0]   BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [8:0]         BURST_LEN9  = 9'(BURST_LEN);
  localparam logic [USEDW_W-1:0] DEPTH_U     = USEDW_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0]  BASE_U      = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE, FLUSH, CHECK, REQ, XFER, DONE
  } state_t;

  // Control registers (reset)
  state_t              state_q, state_d;
  logic                sync_q, sync_d;
  logic                restart_pend_q, restart_pend_d;
  logic [7:0]          overrun_q, overrun_d;
  logic                fifo_flush_q, fifo_flush_d;
  logic                rd_req_q, rd_req_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [8:0]          rd_len_q, rd_len_d;

  // Datapath registers (always loaded in FLUSH before use, so not reset)
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic [CNT_W-1:0]    words_left_q, words_left_d;

  logic                fs;
  logic                overrun_inc;
  logic [8:0]          len_w;
  logic [USEDW_W-1:0]  free_w;
  logic                room_ok;

  assign fs = sync_q & ~lcd_framesync;

  always_comb begin
    if (words_left_q >= BURST_CNT) len_w = BURST_LEN9;
    else                           len_w = words_left_q[8:0];

    // A fill level at or above depth is treated as no room at all.
    if (bus.fifo_wrusedw >= DEPTH_U) free_w = '0;
    else                             free_w = DEPTH_U - bus.fifo_wrusedw;

    room_ok = 32'(free_w) >= 32'(len_w);
  end

  always_comb begin
    state_d        = state_q;
    sync_d         = lcd_framesync;
    restart_pend_d = restart_pend_q;
    overrun_inc    = 1'b0;
    rd_addr_d      = rd_addr_q;
    rd_len_d       = rd_len_q;
    addr_ptr_d     = addr_ptr_q;
    words_left_d   = words_left_q;

    case (state_q)
      IDLE: begin
        if (fs && enable) state_d = FLUSH;
      end
      FLUSH: begin
        addr_ptr_d     = BASE_U;
        words_left_d   = FRAME_WORDS;
        restart_pend_d = 1'b0;
        state_d        = CHECK;
      end
      CHECK: begin
        // No burst is in flight here, so a new frame restarts immediately.
        if (fs) begin
          overrun_inc = 1'b1;
          state_d     = FLUSH;
        end else if (words_left_q == '0) begin
          state_d = DONE;
        end else if (room_ok) begin
          rd_addr_d = addr_ptr_q;
          rd_len_d  = len_w;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (fs) begin
          restart_pend_d = 1'b1;
          overrun_inc    = 1'b1;
        end
        if (bus.rd_ack) state_d = XFER;
      end
      XFER: begin
        if (fs) begin
          restart_pend_d = 1'b1;
          overrun_inc    = 1'b1;
        end
        if (bus.rd_done) begin
          addr_ptr_d   = addr_ptr_q + ADDR_W'(rd_len_q);
          words_left_d = words_left_q - CNT_W'(rd_len_q);
          // A frame start in this very cycle counts as pending too.
          if (restart_pend_q || fs) state_d = enable ? FLUSH : IDLE;
          else                      state_d = CHECK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (overrun_inc && overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
    else                                   overrun_d = overrun_q;

    // Outputs are registered copies of the next-state decode.
    fifo_flush_d = (state_d == FLUSH);
    rd_req_d     = (state_d == REQ);
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sync_q         <= 1'b1;
      restart_pend_q <= 1'b0;
      overrun_q      <= 8'd0;
      fifo_flush_q   <= 1'b0;
      rd_req_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      rd_addr_q      <= BASE_U;
      rd_len_q       <= 9'd0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      restart_pend_q <= restart_pend_d;
      overrun_q      <= overrun_d;
      fifo_flush_q   <= fifo_flush_d;
      rd_req_q       <= rd_req_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
      rd_addr_q      <= rd_addr_d;
      rd_len_q       <= rd_len_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_ptr_q   <= addr_ptr_d;
    words_left_q <= words_left_d;
  end

  assign bus.fifo_flush = fifo_flush_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_len     = rd_len_q;
  assign frame_done     = frame_done_q;
  assign busy           = busy_q;
  assign overrun_cnt    = overrun_q;

endmodule

// File: tb/tb_lcd_frame_prefetch_ctrl.sv
// Directed bench for lcd_frame_prefetch_ctrl using a tiny 4x2 frame with
// 3-word bursts based at word address 0x100.
module tb_lcd_frame_prefetch_ctrl;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       lcd_framesync;
  logic       frame_done;
  logic       busy;
  logic [7:0] overrun_cnt;

  int checks;
  int failures;

  lcd_frame_prefetch_ctrl_if #(.ADDR_W(24), .USEDW_W(10)) bif ();

  lcd_frame_prefetch_ctrl #(
    .H_DISP(4), .V_DISP(2), .BURST_LEN(3), .FIFO_DEPTH(512),
    .ADDR_W(24), .BASE_ADDR(32'h100), .CNT_W(18)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .lcd_framesync (lcd_framesync),
    .bus           (bif.master),
    .frame_done    (frame_done),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (bif.rd_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("rd_req_seen", {31'd0, bif.rd_req}, 32'd1);
  endtask

  // One full burst: wait for the request, hold ack off for ack_delay cycles,
  // accept, then return rd_done two cycles later.
  task automatic do_burst(input logic [23:0] ea, input logic [8:0] el, input int ack_delay);
    wait_req();
    check("rd_addr", {8'd0, bif.rd_addr}, {8'd0, ea});
    check("rd_len", {23'd0, bif.rd_len}, {23'd0, el});
    for (int i = 0; i < ack_delay; i++) begin
      step();
      check("req_held", {31'd0, bif.rd_req}, 32'd1);
      check("addr_held", {8'd0, bif.rd_addr}, {8'd0, ea});
      check("len_held", {23'd0, bif.rd_len}, {23'd0, el});
    end
    bif.rd_ack = 1'b1;
    step();
    bif.rd_ack = 1'b0;
    check("req_drop_after_ack", {31'd0, bif.rd_req}, 32'd0);
    step();
    bif.rd_done = 1'b1;
    step();
    bif.rd_done = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    enable        = 1'b0;
    lcd_framesync = 1'b1;
    bif.fifo_wrusedw = '0;
    bif.rd_ack    = 1'b0;
    bif.rd_done   = 1'b0;
    step(); step(); step();

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_req", {31'd0, bif.rd_req}, 32'd0);
    check("rst_rd_addr", {8'd0, bif.rd_addr}, 32'h100);
    check("rst_rd_len", {23'd0, bif.rd_len}, 32'd0);
    check("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
    check("rst_flush", {31'd0, bif.fifo_flush}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    step();

    // Basic frame: bursts (0x100,3) (0x103,3) (0x106,2)
    enable = 1'b1;
    lcd_framesync = 1'b0;
    step();
    check("t1_flush", {31'd0, bif.fifo_flush}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    step();
    check("t1_flush_single", {31'd0, bif.fifo_flush}, 32'd0);
    do_burst(24'h100, 9'd3, 0);
    do_burst(24'h103, 9'd3, 0);
    do_burst(24'h106, 9'd2, 0);
    step();
    check("t1_frame_done", {31'd0, frame_done}, 32'd1);
    step();
    check("t1_frame_done_clr", {31'd0, frame_done}, 32'd0);
    check("t1_busy_idle", {31'd0, busy}, 32'd0);

    // FIFO stall, then slow ack
    lcd_framesync = 1'b1;
    step();
    bif.fifo_wrusedw = 10'd510;
    lcd_framesync = 1'b0;
    step();
    check("t2_flush", {31'd0, bif.fifo_flush}, 32'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_stall_no_req", {31'd0, bif.rd_req}, 32'd0);
      check("t2_stall_busy", {31'd0, busy}, 32'd1);
    end
    bif.fifo_wrusedw = 10'd509;
    step();
    check("t2_req_after_room", {31'd0, bif.rd_req}, 32'd1);
    do_burst(24'h100, 9'd3, 10);
    bif.fifo_wrusedw = 10'd0;
    do_burst(24'h103, 9'd3, 0);
    do_burst(24'h106, 9'd2, 0);
    step();
    check("t2_frame_done", {31'd0, frame_done}, 32'd1);
    step();
    check("t2_busy_idle", {31'd0, busy}, 32'd0);

    // Frame start during XFER restarts after the burst completes
    lcd_framesync = 1'b1;
    step();
    lcd_framesync = 1'b0;
    step();
    check("t4_flush", {31'd0, bif.fifo_flush}, 32'd1);
    wait_req();
    check("t4_addr0", {8'd0, bif.rd_addr}, 32'h100);
    bif.rd_ack = 1'b1;
    step();
    bif.rd_ack = 1'b0;
    lcd_framesync = 1'b1;
    step();
    lcd_framesync = 1'b0;
    step();
    check("t4_overrun", {24'd0, overrun_cnt}, 32'd1);
    check("t4_no_flush_yet", {31'd0, bif.fifo_flush}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd1);
    bif.rd_done = 1'b1;
    step();
    bif.rd_done = 1'b0;
    check("t4_flush_after_done", {31'd0, bif.fifo_flush}, 32'd1);
    step();
    do_burst(24'h100, 9'd3, 0);
    do_burst(24'h103, 9'd3, 0);
    lcd_framesync = 1'b1;
    do_burst(24'h106, 9'd2, 0);
    step();
    check("t4_frame_done", {31'd0, frame_done}, 32'd1);
    // Frame start landing on DONE is missed
    lcd_framesync = 1'b0;
    step();
    check("t4_done_fs_busy", {31'd0, busy}, 32'd0);
    check("t4_done_fs_overrun", {24'd0, overrun_cnt}, 32'd1);
    step();
    check("t4_done_fs_no_flush", {31'd0, bif.fifo_flush}, 32'd0);
    check("t4_done_fs_idle", {31'd0, busy}, 32'd0);

    // enable low at frame start: ignored
    lcd_framesync = 1'b1;
    step();
    enable = 1'b0;
    lcd_framesync = 1'b0;
    step();
    check("t5_no_flush", {31'd0, bif.fifo_flush}, 32'd0);
    check("t5_not_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_idle_busy", {31'd0, busy}, 32'd0);
      check("t5_idle_req", {31'd0, bif.rd_req}, 32'd0);
    end

    // Repeated frame starts while stalled in CHECK: saturation
    lcd_framesync = 1'b1;
    enable = 1'b1;
    step();
    lcd_framesync = 1'b0;
    bif.fifo_wrusedw = 10'd512;
    step();
    check("t5_flush_start", {31'd0, bif.fifo_flush}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      lcd_framesync = 1'b1;
      step();
      lcd_framesync = 1'b0;
      step();
      if (i == 99) check("t5_overrun_101", {24'd0, overrun_cnt}, 32'd101);
    end
    check("t5_overrun_sat", {24'd0, overrun_cnt}, 32'd255);

    // Reset while in REQ
    lcd_framesync = 1'b1;
    bif.fifo_wrusedw = 10'd0;
    wait_req();
    check("t6_addr_before_rst", {8'd0, bif.rd_addr}, 32'h100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rd_req", {31'd0, bif.rd_req}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_rd_addr", {8'd0, bif.rd_addr}, 32'h100);
    check("t6_rd_len", {23'd0, bif.rd_len}, 32'd0);
    check("t6_overrun", {24'd0, overrun_cnt}, 32'd0);
    bif.rd_done = 1'b1;
    step();
    bif.rd_done = 1'b0;
    check("t6_done_ignored", {31'd0, busy}, 32'd0);
    step();
    check("t6_no_req", {31'd0, bif.rd_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
